nios2_hello_ram_tester: RTL and testbench

//  Avalon-MM master (initiator) that drives the on-chip RAM slave s1 from the far side.
//  On a start pulse it writes a deterministic pattern over a word range, reads the range

---
 rtl/nios2_hello_ram_tester_if.sv | 24 ++
 rtl/nios2_hello_ram_tester.sv | 159 +++++++++++++++
 tb/tb_nios2_hello_ram_tester.sv | 321 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/nios2_hello_ram_tester_if.sv
// Avalon-MM bus between the RAM self-test initiator and the on-chip RAM slave s1.
interface nios2_hello_ram_tester_if #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   address;
  logic [DATA_W/8-1:0] byteenable;
  logic                write;
  logic [DATA_W-1:0]   writedata;
  logic                read;
  logic                waitrequest;
  logic [DATA_W-1:0]   readdata;
  logic                readdatavalid;

  modport master (
    output address, byteenable, write, writedata, read,
    input  waitrequest, readdata, readdatavalid
  );

  modport slave (
    input  address, byteenable, write, writedata, read,
    output waitrequest, readdata, readdatavalid
  );
endinterface

// File: rtl/nios2_hello_ram_tester.sv
// RAM self-test initiator: writes seed+i over a wrapping word range, reads it back,
// counts mismatches and records the first failing address.
//
// state  | meaning
// IDLE   | waiting for start; results from the last run held
// WR     | writing word i, held while waitrequest
// RD     | read request for word i, held while waitrequest
// RDWAIT | one read outstanding; compare once the captured data is valid
// DONE   | one-cycle done pulse, pass reported
module nios2_hello_ram_tester #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 14
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  word_count,
  input  logic [DATA_W-1:0] seed,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [15:0]       err_count,
  output logic [ADDR_W-1:0] first_err_addr,
  nios2_hello_ram_tester_if.master avm
);

  typedef enum logic [2:0] {IDLE, WR, RD, RDWAIT, DONE} state_t;

  state_t            state, state_nx;
  logic [CNT_W-1:0]  idx, idx_nx;
  logic [CNT_W-1:0]  count_q, count_nx;
  logic [ADDR_W-1:0] base_q, base_nx;
  logic [DATA_W-1:0] seed_q, seed_nx;
  logic [15:0]       err_nx;
  logic [ADDR_W-1:0] ferr_nx;
  logic              pass_nx;
  logic              rdv_q;
  logic [DATA_W-1:0] rd_q;

  logic [ADDR_W-1:0] cur_addr;
  logic [DATA_W-1:0] cur_data;
  logic              last;
  logic              mismatch;

  assign cur_addr = base_q + idx[ADDR_W-1:0];
  assign cur_data = seed_q + DATA_W'(idx);
  assign last     = (idx == count_q - CNT_W'(1));
  assign mismatch = (rd_q != cur_data);

  always_comb begin
    state_nx       = state;
    idx_nx         = idx;
    count_nx       = count_q;
    base_nx        = base_q;
    seed_nx        = seed_q;
    err_nx         = err_count;
    ferr_nx        = first_err_addr;
    pass_nx        = pass;
    busy           = 1'b0;
    done           = 1'b0;
    avm.write      = 1'b0;
    avm.read       = 1'b0;
    avm.address    = '0;
    avm.writedata  = '0;
    avm.byteenable = '0;
    unique case (state)
      IDLE: begin
        if (start) begin
          base_nx  = base_addr;
          count_nx = word_count;
          seed_nx  = seed;
          idx_nx   = '0;
          err_nx   = '0;
          ferr_nx  = '0;
          if (word_count == '0) begin
            pass_nx  = 1'b1;
            state_nx = DONE;
          end else begin
            pass_nx  = 1'b0;
            state_nx = WR;
          end
        end
      end
      WR: begin
        busy           = 1'b1;
        avm.write      = 1'b1;
        avm.address    = cur_addr;
        avm.writedata  = cur_data;
        avm.byteenable = '1;
        if (!avm.waitrequest) begin
          if (last) begin
            idx_nx   = '0;
            state_nx = RD;
          end else begin
            idx_nx = idx + CNT_W'(1);
          end
        end
      end
      RD: begin
        busy           = 1'b1;
        avm.read       = 1'b1;
        avm.address    = cur_addr;
        avm.byteenable = '1;
        if (!avm.waitrequest) state_nx = RDWAIT;
      end
      RDWAIT: begin
        busy = 1'b1;
        if (rdv_q) begin
          if (mismatch) begin
            if (err_count != 16'hFFFF) err_nx = err_count + 16'd1;
            if (err_count == 16'd0)    ferr_nx = cur_addr;
          end
          if (last) begin
            pass_nx  = (err_count == 16'd0) && !mismatch;
            state_nx = DONE;
          end else begin
            idx_nx   = idx + CNT_W'(1);
            state_nx = RD;
          end
        end
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Read data is captured before comparing; valid is only taken while a read is outstanding.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      idx            <= '0;
      count_q        <= '0;
      base_q         <= '0;
      seed_q         <= '0;
      err_count      <= '0;
      first_err_addr <= '0;
      pass           <= 1'b0;
      rdv_q          <= 1'b0;
      rd_q           <= '0;
    end else begin
      state          <= state_nx;
      idx            <= idx_nx;
      count_q        <= count_nx;
      base_q         <= base_nx;
      seed_q         <= seed_nx;
      err_count      <= err_nx;
      first_err_addr <= ferr_nx;
      pass           <= pass_nx;
      rdv_q          <= avm.readdatavalid && (state == RDWAIT) && !rdv_q;
      rd_q           <= avm.readdata;
    end
  end

endmodule

// File: tb/tb_nios2_hello_ram_tester.sv
// Bench for the RAM self-test initiator: RAM model with optional stalls and faults,
// a transaction-level expectation model and directed scenarios.
module tb_nios2_hello_ram_tester;
  localparam int ADDR_W = 13;
  localparam int DATA_W = 32;
  localparam int CNT_W  = 14;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic [CNT_W-1:0]  word_count = '0;
  logic [DATA_W-1:0] seed = '0;
  logic              busy, done, pass;
  logic [15:0]       err_count;
  logic [ADDR_W-1:0] first_err_addr;

  nios2_hello_ram_tester_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) avm ();

  nios2_hello_ram_tester #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .base_addr      (base_addr),
    .word_count     (word_count),
    .seed           (seed),
    .busy           (busy),
    .done           (done),
    .pass           (pass),
    .err_count      (err_count),
    .first_err_addr (first_err_addr),
    .avm            (avm)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // RAM slave: latency-1 reads, optional random stalls, optional read corruption
  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
  int fault = 0;
  bit stall_en = 1'b0;
  bit inject = 1'b0;

  initial begin
    bit pend;
    logic [DATA_W-1:0] pval;
    for (int k = 0; k < (1 << ADDR_W); k++) mem[k] = '0;
    avm.waitrequest = 1'b0;
    avm.readdata = '0;
    avm.readdatavalid = 1'b0;
    pend = 1'b0;
    pval = '0;
    forever begin
      @(negedge clk);
      pend = 1'b0;
      if (!reset && avm.write && !avm.waitrequest) mem[avm.address] = avm.writedata;
      if (!reset && avm.read && !avm.waitrequest) begin
        pend = 1'b1;
        pval = mem[avm.address];
        if (fault == 1 && avm.address == 13'h013) pval[0] = ~pval[0];
        else if (fault == 2) pval = ~pval;
      end
      @(posedge clk);
      #1;
      avm.readdatavalid = pend || inject;
      avm.readdata = inject ? 32'hDEAD_BEEF : (pend ? pval : '0);
      avm.waitrequest = stall_en ? 1'($urandom_range(0, 1)) : 1'b0;
    end
  end

  // Expected transactions and results for the current run
  logic [ADDR_W-1:0] q_wa[$], q_ra[$], wr_log[$];
  logic [DATA_W-1:0] q_wd[$], wd_log[$];
  logic [15:0]       exp_err;
  logic [ADDR_W-1:0] exp_first;
  bit                exp_pass;
  bit check_en = 1'b0, active = 1'b0, done_seen = 1'b0;
  int start_cyc = 0, done_cyc = 0;

  initial begin
    bit prev_stall, prev_done, prev_rd, prev_wr;
    logic [ADDR_W-1:0] prev_addr;
    logic [DATA_W-1:0] prev_wd;
    prev_stall = 1'b0; prev_done = 1'b0; prev_rd = 1'b0; prev_wr = 1'b0;
    prev_addr = '0; prev_wd = '0;
    forever begin
      @(negedge clk);
      if (check_en && !reset) begin
        chk("rd_wr_exclusive", avm.read && avm.write, 0);
        if (avm.read || avm.write) begin
          chk("byteenable", avm.byteenable, 4'hF);
          chk("busy_with_req", busy, 1);
        end
        if (!active) chk("idle_no_req", {avm.read, avm.write}, 0);
        if (prev_stall)
          chk("stall_stable", {avm.address, avm.writedata, avm.read, avm.write},
              {prev_addr, prev_wd, prev_rd, prev_wr});
        if (prev_done) chk("done_one_cycle", done, 0);
        if (avm.write && !avm.waitrequest) begin
          wr_log.push_back(avm.address);
          wd_log.push_back(avm.writedata);
          if (q_wa.size() == 0) chk("unexpected_write", avm.write, 0);
          else begin
            chk("wr_addr", avm.address, q_wa.pop_front());
            chk("wr_data", avm.writedata, q_wd.pop_front());
          end
        end
        if (avm.read && !avm.waitrequest) begin
          if (q_ra.size() == 0) chk("unexpected_read", avm.read, 0);
          else chk("rd_addr", avm.address, q_ra.pop_front());
        end
        if (done) begin
          chk("done_busy_low", busy, 0);
          chk("pass", pass, exp_pass);
          chk("err_count", err_count, exp_err);
          if (!exp_pass) chk("first_err_addr", first_err_addr, exp_first);
          chk("writes_left", q_wa.size(), 0);
          chk("reads_left", q_ra.size(), 0);
          active = 1'b0;
          done_seen = 1'b1;
          done_cyc = cyc;
        end
        prev_stall = (avm.read || avm.write) && avm.waitrequest;
        prev_done = done;
        prev_addr = avm.address;
        prev_wd = avm.writedata;
        prev_rd = avm.read;
        prev_wr = avm.write;
      end else begin
        prev_stall = 1'b0;
        prev_done = 1'b0;
      end
    end
  end

  task automatic launch(input logic [ADDR_W-1:0] b, input logic [CNT_W-1:0] n,
                        input logic [DATA_W-1:0] s, input int f);
    logic [ADDR_W-1:0] a;
    @(posedge clk);
    #2;
    fault = f;
    q_wa.delete(); q_wd.delete(); q_ra.delete(); wr_log.delete(); wd_log.delete();
    exp_err = '0;
    exp_first = '0;
    for (int i = 0; i < int'(n); i++) begin
      a = b + ADDR_W'(i);
      q_wa.push_back(a);
      q_wd.push_back(s + DATA_W'(i));
      q_ra.push_back(a);
      if ((f == 1 && a == 13'h013) || f == 2) begin
        if (exp_err == 16'd0) exp_first = a;
        if (exp_err != 16'hFFFF) exp_err = exp_err + 16'd1;
      end
    end
    exp_pass = (exp_err == 16'd0);
    done_seen = 1'b0;
    active = 1'b1;
    base_addr = b;
    word_count = n;
    seed = s;
    start = 1'b1;
    start_cyc = cyc;
    @(posedge clk);
    #2;
    start = 1'b0;
  endtask

  task automatic wait_done(input int limit, input string name);
    int k;
    k = 0;
    while (!done_seen && k < limit) begin
      @(negedge clk);
      #1;
      k++;
    end
    chk(name, done_seen, 1);
    if (!done_seen) active = 1'b0;
  endtask

  initial begin
    int k;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_err", err_count, 0);
    chk("rst_write", avm.write, 0);
    chk("rst_read", avm.read, 0);
    @(posedge clk);
    #2;
    reset = 1'b0;
    check_en = 1'b1;

    // Basic run with literal pins
    launch(13'h010, 14'd8, 32'hA5A5_0000, 0);
    wait_done(200, "t1_done");
    chk("t1_span", 64'(done_cyc - start_cyc + 1), 64'd34);
    chk("t1_pass_lit", pass, 1);
    chk("t1_err_lit", err_count, 0);
    chk("t1_nwr", wr_log.size(), 8);
    if (wr_log.size() == 8) begin
      chk("t1_a0_lit", wr_log[0], 13'h010);
      chk("t1_d0_lit", wd_log[0], 32'hA5A5_0000);
      chk("t1_a7_lit", wr_log[7], 13'h017);
      chk("t1_d7_lit", wd_log[7], 32'hA5A5_0007);
    end

    // Single corrupted word
    launch(13'h010, 14'd8, 32'hA5A5_0000, 1);
    wait_done(200, "t2_done");
    chk("t2_pass_lit", pass, 0);
    chk("t2_err_lit", err_count, 1);
    chk("t2_first_lit", first_err_addr, 13'h013);

    // Zero-length run clears the previous failure
    launch(13'h055, 14'd0, 32'h1, 0);
    wait_done(20, "t4z_done");
    chk("t4z_span", 64'(done_cyc - start_cyc + 1), 64'd2);
    chk("t4z_pass_lit", pass, 1);
    chk("t4z_err_lit", err_count, 0);

    // Random stalls
    stall_en = 1'b1;
    launch(13'h010, 14'd8, 32'hA5A5_0000, 0);
    wait_done(2000, "t3_done");
    stall_en = 1'b0;
    chk("t3_pass_lit", pass, 1);
    chk("t3_err_lit", err_count, 0);

    // Address and data wrap
    launch(13'h1FFE, 14'd4, 32'hFFFF_FFFE, 0);
    wait_done(200, "t4_done");
    chk("t4_nwr", wr_log.size(), 4);
    if (wr_log.size() == 4) begin
      chk("t4_a0_lit", wr_log[0], 13'h1FFE);
      chk("t4_a1_lit", wr_log[1], 13'h1FFF);
      chk("t4_a2_lit", wr_log[2], 13'h000);
      chk("t4_a3_lit", wr_log[3], 13'h001);
      chk("t4_d2_lit", wd_log[2], 32'h0000_0000);
    end

    // Reset during WR at i=3, then a stray readdatavalid
    launch(13'h040, 14'd8, 32'h1234_0000, 0);
    k = 0;
    while (!(avm.write && avm.address == 13'h043) && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("t5_reached_i3", avm.address, 13'h043);
    check_en = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    chk("t5_write", avm.write, 0);
    chk("t5_read", avm.read, 0);
    chk("t5_addr", avm.address, 0);
    chk("t5_wdata", avm.writedata, 0);
    chk("t5_busy", busy, 0);
    chk("t5_pass", pass, 0);
    chk("t5_err", err_count, 0);
    reset = 1'b0;
    active = 1'b0;
    q_wa.delete(); q_wd.delete(); q_ra.delete();
    inject = 1'b1;
    @(negedge clk);
    inject = 1'b0;
    @(negedge clk);
    chk("t5_late_busy", busy, 0);
    chk("t5_late_err", err_count, 0);
    chk("t5_late_done", done, 0);
    chk("t5_late_req", {avm.read, avm.write}, 0);
    check_en = 1'b1;
    launch(13'h040, 14'd8, 32'h1234_0000, 0);
    wait_done(200, "t5_clean_done");
    chk("t5_clean_pass", pass, 1);

    // Start pulsed during RD is ignored
    launch(13'h020, 14'd8, 32'h0F0F_0000, 0);
    k = 0;
    while (!avm.read && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("t6_reached_rd", avm.read, 1);
    base_addr = 13'h500;
    word_count = 14'd3;
    seed = 32'h0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(200, "t6_done");
    chk("t6_span", 64'(done_cyc - start_cyc + 1), 64'd34);
    chk("t6_pass", pass, 1);
    repeat (3) @(negedge clk);
    chk("t6_no_restart", busy, 0);

    // Full memory, every read corrupted
    launch(13'h100, 14'd8192, 32'h0, 2);
    wait_done(40000, "t6f_done");
    chk("t6f_err_lit", err_count, 16'd8192);
    chk("t6f_first_lit", first_err_addr, 13'h100);
    chk("t6f_pass_lit", pass, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
